// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide engine: shift-add multiply and restoring divide over
// WIDTH cycles on magnitudes, with sign fix-up and the architectural Hi/Lo registers.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] MultA,
  input  logic [WIDTH-1:0] MultB,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   count;
  logic               opDiv, signA, signB, divZeroFlag;
  logic [WIDTH-1:0]   opA, opB;
  logic [2*WIDTH-1:0] acc;

  function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] negW(input logic signed [WIDTH-1:0] x);
    return -x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2W(input logic signed [2*WIDTH-1:0] x);
    return -x;
  endfunction

  logic accept, isDivZero;
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign isDivZero = op && (MultB == '0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    div_zero  = 1'b0;
    case (state)
      IDLE, DONE: begin
        done     = (state == DONE);
        div_zero = (state == DONE) && divZeroFlag;
        if (start) stateNext = isDivZero ? DONE : RUN;
        else       stateNext = IDLE;
      end
      RUN: begin
        busy = 1'b1;
        if (count == '0) stateNext = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Multiply step: conditional add into the upper half, then shift right with the carry.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  assign addend  = opB[0] ? opA : '0;
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign mulNext = {mulSum, acc[WIDTH-1:1]};

  // Divide step: dividend bits enter from the top of opA; a negative trial means restore.
  logic [WIDTH:0]     remShift;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] divNext;
  assign remShift = {acc[2*WIDTH-1:WIDTH], opA[WIDTH-1]};
  assign trial    = {1'b0, remShift} - {2'b00, opB};
  assign divNext  = trial[WIDTH+1] ? {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prodFinal;
  logic [WIDTH-1:0]   quotFinal, remFinal;
  assign prodFinal = (signA ^ signB) ? neg2W(acc) : acc;
  assign quotFinal = (signA ^ signB) ? negW(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign remFinal  = signA ? negW(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      acc         <= '0;
      opA         <= '0;
      opB         <= '0;
      opDiv       <= 1'b0;
      signA       <= 1'b0;
      signB       <= 1'b0;
      divZeroFlag <= 1'b0;
      Hi          <= '0;
      Lo          <= '0;
    end else begin
      divZeroFlag <= accept && isDivZero;
      if (accept && !isDivZero) begin
        signA <= MultA[WIDTH-1];
        signB <= MultB[WIDTH-1];
        opDiv <= op;
        opA   <= absVal(MultA);
        opB   <= absVal(MultB);
        acc   <= '0;
        count <= CNT_W'(WIDTH - 1);
      end else if (state == RUN) begin
        if (count != '0) count <= count - CNT_W'(1);
        if (opDiv) begin
          acc <= divNext;
          opA <= {opA[WIDTH-2:0], 1'b0};
        end else begin
          acc <= mulNext;
          opB <= {1'b0, opB[WIDTH-1:1]};
        end
      end else if (state == FIX) begin
        if (opDiv) begin
          Hi <= remFinal;
          Lo <= quotFinal;
        end else begin
          Hi <= prodFinal[2*WIDTH-1:WIDTH];
          Lo <= prodFinal[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random operations
// compared against a 64-bit signed arithmetic model of Hi/Lo.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          op    = 1'b0;
  logic [W-1:0]  MultA = '0;
  logic [W-1:0]  MultB = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  Hi, Lo;

  int            errors = 0;
  int            checks = 0;
  logic [31:0]   expHi  = '0;
  logic [31:0]   expLo  = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .MultA(MultA), .MultB(MultB),
    .busy(busy), .done(done), .div_zero(div_zero), .Hi(Hi), .Lo(Lo)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pickOperand();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic runOp(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    bit     dz, busyBad;
    int     cyc;
    sa = $signed(a);
    sb = $signed(b);
    dz = o && (b == 32'd0);
    if (!dz) begin
      if (!o) begin
        p = sa * sb;
        expHi = p[63:32];
        expLo = p[31:0];
      end else begin
        q = sa / sb;
        r = sa % sb;
        expHi = r[31:0];
        expLo = q[31:0];
      end
    end
    @(negedge clock);
    start = 1'b1; op = o; MultA = a; MultB = b;
    @(posedge clock); #1;
    start = 1'b0; op = 1'($urandom_range(0, 1)); MultA = $urandom; MultB = $urandom;
    if (dz) begin
      checkVal("dz_done",  64'(done), 64'd1);
      checkVal("dz_flag",  64'(div_zero), 64'd1);
      checkVal("dz_busy",  64'(busy), 64'd0);
      checkVal("dz_hi",    64'(Hi), 64'(expHi));
      checkVal("dz_lo",    64'(Lo), 64'(expLo));
    end else begin
      cyc = 1;
      busyBad = 1'b0;
      while (!done && cyc < 40) begin
        if (busy !== 1'b1 || div_zero !== 1'b0) busyBad = 1'b1;
        @(posedge clock); #1;
        cyc++;
      end
      checkVal("latency",   64'(cyc), 64'd34);
      checkVal("busy_run",  64'(busyBad), 64'd0);
      checkVal("busy_done", 64'(busy), 64'd0);
      checkVal("dz_clear",  64'(div_zero), 64'd0);
      checkVal("hi",        64'(Hi), 64'(expHi));
      checkVal("lo",        64'(Lo), 64'(expLo));
    end
    @(posedge clock); #1;
    checkVal("done_pulse", 64'(done), 64'd0);
    checkVal("hold_hi",    64'({Hi, Lo}), {expHi, expLo});
  endtask

  initial begin
    bit sawDone, doneBad;
    logic o;
    logic [31:0] a, b;

    repeat (3) @(posedge clock);
    #1;
    checkVal("rst_busy", 64'(busy), 64'd0);
    checkVal("rst_done", 64'(done), 64'd0);
    checkVal("rst_dz",   64'(div_zero), 64'd0);
    checkVal("rst_hilo", 64'({Hi, Lo}), 64'd0);
    reset = 1'b0;

    runOp(1'b0, 32'd7, 32'hFFFF_FFFD);

    // Abort a multiply with reset in cycle 10.
    @(negedge clock);
    start = 1'b1; op = 1'b0; MultA = 32'd9; MultB = 32'd11;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checkVal("abort_busy", 64'(busy), 64'd0);
    checkVal("abort_done", 64'(done), 64'd0);
    checkVal("abort_hilo", 64'({Hi, Lo}), 64'd0);
    reset = 1'b0;
    expHi = '0; expLo = '0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) sawDone = 1'b1;
    end
    checkVal("abort_nodone", 64'(sawDone), 64'd0);
    runOp(1'b0, 32'd2, 32'd2);

    runOp(1'b0, 32'h8000_0000, 32'h8000_0000);
    runOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp(1'b1, 32'hFFFF_FFF9, 32'd2);
    runOp(1'b1, 32'd100, 32'd7);
    runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp(1'b1, 32'h0000_1234, 32'h0001_0000);
    checkVal("pre_dz_hi", 64'(Hi), 64'h1234);
    runOp(1'b1, 32'd5, 32'd0);

    // start held high: back-to-back 3x4, with operand and start noise in cycles 5..20.
    @(negedge clock);
    start = 1'b1; op = 1'b0; MultA = 32'd3; MultB = 32'd4;
    @(posedge clock);
    doneBad = 1'b0;
    for (int cyc = 1; cyc <= 102; cyc++) begin
      #1;
      if (done !== (cyc % 34 == 0)) doneBad = 1'b1;
      if (cyc % 34 == 0) checkVal("b2b_hilo", 64'({Hi, Lo}), 64'd12);
      if (cyc >= 5 && cyc <= 20) begin
        start = 1'($urandom_range(0, 1));
        op    = 1'($urandom_range(0, 1));
        MultA = $urandom;
        MultB = $urandom;
      end else begin
        start = (cyc < 102);
        op    = 1'b0;
        MultA = 32'd3;
        MultB = 32'd4;
      end
      @(posedge clock);
    end
    #1;
    start = 1'b0;
    checkVal("b2b_done_pattern", 64'(doneBad), 64'd0);
    expHi = '0; expLo = 32'd12;

    for (int i = 0; i < 60; i++) begin
      o = 1'($urandom_range(0, 1));
      a = pickOperand();
      b = pickOperand();
      runOp(o, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
